// File: rtl/eth_encap_if.sv
// AXI-Stream style 64-bit byte stream with per-lane keep; master drives data, slave drives tready.
interface eth_encap_if;
   logic        tvalid;
   logic        tready;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tlast;
   logic        tuser;

   modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/eth_encap.sv
// Buffers one TLP, then emits it as an Ethernet/IPv4/UDP/NetTLP frame; first header word 2 cycles after tlast.
// Input is held off from tlast until the frame's last word is taken; output stalls losslessly on eth_tx.tready.
module eth_encap #(
   parameter int         BUF_DEPTH = 64,
   parameter logic [7:0] IP_TTL    = 8'd64
) (
   input  logic        eth_clk,
   input  logic        eth_rst,
   eth_encap_if.slave  tlp,
   eth_encap_if.master eth_tx,
   input  logic [47:0] src_mac,
   input  logic [47:0] dst_mac,
   input  logic [31:0] src_ip,
   input  logic [31:0] dst_ip,
   input  logic [15:0] src_port,
   input  logic [15:0] dst_port,
   input  logic [31:0] tstamp,
   output logic [15:0] drop_cnt
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam logic [AW:0] FULL_PTR = (AW+1)'(BUF_DEPTH);
   localparam logic [AW:0] ONE      = (AW+1)'(1);

   typedef enum logic [2:0] {S_FILL, S_CSUM, S_HDR, S_DATA, S_DROP} state_t;

   state_t      state;
   logic [63:0] buf_dat  [BUF_DEPTH];
   logic [7:0]  buf_keep [BUF_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [2:0]  hdr_idx;
   logic [15:0] byte_cnt;
   logic [15:0] ip_len;
   logic [15:0] udp_len;
   logic [15:0] csum;
   logic [15:0] seq;
   logic [31:0] ts_lat;
   logic        tlp_rdy;
   logic        tx_vld;
   logic [63:0] tx_dat;
   logic [7:0]  tx_keep;
   logic        tx_last;

   logic        tlp_acc;
   logic        wr_full;
   logic [15:0] ip_len_c;
   logic [31:0] csum_sum;
   logic [16:0] csum_f1;
   logic [15:0] csum_f2;
   logic [383:0] hdr_be;
   logic [383:0] hdr_sh;
   logic [63:0] hdr_w;

   function automatic logic [3:0] popcnt(input logic [7:0] k);
      popcnt = '0;
      for (int i = 0; i < 8; i++) popcnt = popcnt + {3'b0, k[i]};
   endfunction

   assign tlp.tready    = tlp_rdy;
   assign eth_tx.tvalid = tx_vld;
   assign eth_tx.tdata  = tx_dat;
   assign eth_tx.tkeep  = tx_keep;
   assign eth_tx.tlast  = tx_last;
   assign eth_tx.tuser  = 1'b0;

   assign tlp_acc  = tlp.tvalid & tlp_rdy;
   assign wr_full  = (wr_ptr == FULL_PTR);
   assign ip_len_c = 16'd34 + byte_cnt;

   // Header checksum over the ten IPv4 header words with the checksum field zero.
   always_comb begin
      csum_sum = 32'h4500 + {16'h0, ip_len_c} + {16'h0, seq} + 32'h4000 + {16'h0, IP_TTL, 8'd17}
               + {16'h0, src_ip[31:16]} + {16'h0, src_ip[15:0]}
               + {16'h0, dst_ip[31:16]} + {16'h0, dst_ip[15:0]};
      csum_f1  = {1'b0, csum_sum[15:0]} + {1'b0, csum_sum[31:16]};
      csum_f2  = csum_f1[15:0] + {15'b0, csum_f1[16]};
   end

   // Header in wire order with byte 0 at the MSB; each word is byte-swapped onto lane order.
   assign hdr_be = {dst_mac, src_mac, 16'h0800,
                    8'h45, 8'h00, ip_len, seq, 16'h4000, IP_TTL, 8'd17, csum, src_ip, dst_ip,
                    src_port, dst_port, udp_len, 16'h0000,
                    seq, ts_lat};
   assign hdr_sh = hdr_be << {hdr_idx, 6'b0};

   always_comb begin
      hdr_w = '0;
      for (int j = 0; j < 8; j++) hdr_w[8*j +: 8] = hdr_sh[383 - 8*j -: 8];
   end

   always_ff @(posedge eth_clk) begin
      if (state == S_FILL && tlp_acc && !wr_full) begin
         buf_dat[wr_ptr[AW-1:0]]  <= tlp.tdata;
         buf_keep[wr_ptr[AW-1:0]] <= tlp.tkeep;
      end
   end

   always_ff @(posedge eth_clk or posedge eth_rst) begin
      if (eth_rst) begin
         state    <= S_FILL;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         hdr_idx  <= '0;
         byte_cnt <= '0;
         ip_len   <= '0;
         udp_len  <= '0;
         csum     <= '0;
         seq      <= '0;
         ts_lat   <= '0;
         drop_cnt <= '0;
         tlp_rdy  <= 1'b0;
         tx_vld   <= 1'b0;
         tx_dat   <= '0;
         tx_keep  <= '0;
         tx_last  <= 1'b0;
      end else begin
         case (state)
            S_FILL: begin
               tlp_rdy <= 1'b1;
               if (tlp_acc) begin
                  if (wr_full) begin
                     // No room for this word: the TLP is oversize whether or not it is the last.
                     if (tlp.tlast) begin
                        drop_cnt <= drop_cnt + 16'd1;
                        wr_ptr   <= '0;
                        byte_cnt <= '0;
                     end else begin
                        state <= S_DROP;
                     end
                  end else begin
                     wr_ptr   <= wr_ptr + ONE;
                     byte_cnt <= byte_cnt + {12'b0, popcnt(tlp.tkeep)};
                     if (tlp.tlast) begin
                        ts_lat  <= tstamp;
                        tlp_rdy <= 1'b0;
                        state   <= S_CSUM;
                     end
                  end
               end
            end
            S_DROP: begin
               if (tlp_acc && tlp.tlast) begin
                  drop_cnt <= drop_cnt + 16'd1;
                  wr_ptr   <= '0;
                  byte_cnt <= '0;
                  state    <= S_FILL;
               end
            end
            S_CSUM: begin
               ip_len  <= ip_len_c;
               udp_len <= 16'd14 + byte_cnt;
               csum    <= ~csum_f2;
               hdr_idx <= '0;
               state   <= S_HDR;
            end
            S_HDR: begin
               if (!tx_vld || eth_tx.tready) begin
                  tx_vld  <= 1'b1;
                  tx_dat  <= hdr_w;
                  tx_keep <= 8'hFF;
                  tx_last <= 1'b0;
                  if (hdr_idx == 3'd5) begin
                     hdr_idx <= '0;
                     rd_ptr  <= '0;
                     state   <= S_DATA;
                  end else begin
                     hdr_idx <= hdr_idx + 3'd1;
                  end
               end
            end
            S_DATA: begin
               if (tx_vld && eth_tx.tready) begin
                  if (tx_last) begin
                     tx_vld   <= 1'b0;
                     tx_last  <= 1'b0;
                     seq      <= seq + 16'd1;
                     wr_ptr   <= '0;
                     rd_ptr   <= '0;
                     byte_cnt <= '0;
                     tlp_rdy  <= 1'b1;
                     state    <= S_FILL;
                  end else begin
                     tx_dat  <= buf_dat[rd_ptr[AW-1:0]];
                     tx_keep <= buf_keep[rd_ptr[AW-1:0]];
                     tx_last <= (rd_ptr + ONE == wr_ptr);
                     rd_ptr  <= rd_ptr + ONE;
                  end
               end
            end
            default: state <= S_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_encap.sv
// Bench for eth_encap: random TLPs framed by a byte-level reference model, with random output backpressure.
module tb_eth_encap;
   localparam logic [7:0] TTL = 8'd64;

   logic eth_clk = 1'b0;
   logic eth_rst = 1'b1;
   always #5 eth_clk = ~eth_clk;

   eth_encap_if tlp_if ();
   eth_encap_if tx_if ();

   logic [47:0] src_mac  = 48'h02_11_22_33_44_55;
   logic [47:0] dst_mac  = 48'h02_66_77_88_99_aa;
   logic [31:0] src_ip   = 32'hc0a8_0a01;
   logic [31:0] dst_ip   = 32'hc0a8_0a03;
   logic [15:0] src_port = 16'd12288;
   logic [15:0] dst_port = 16'd12289;
   logic [31:0] tstamp   = 32'h1234_0000;
   logic [15:0] drop_cnt;

   always @(posedge eth_clk) #2 tstamp = tstamp + 32'd7;

   eth_encap #(.BUF_DEPTH(64), .IP_TTL(TTL)) dut (
      .eth_clk (eth_clk),
      .eth_rst (eth_rst),
      .tlp     (tlp_if),
      .eth_tx  (tx_if),
      .src_mac (src_mac),
      .dst_mac (dst_mac),
      .src_ip  (src_ip),
      .dst_ip  (dst_ip),
      .src_port(src_port),
      .dst_port(dst_port),
      .tstamp  (tstamp),
      .drop_cnt(drop_cnt)
   );

   int           n_chk = 0;
   int           n_fail = 0;
   logic [15:0]  exp_seq = 16'd0;
   byte unsigned tlp_q[$];
   byte unsigned fr_q[$];
   byte unsigned rx_q[$];
   logic [63:0]  exp_dat[$];
   logic [7:0]   exp_keep[$];
   int           rx_words;
   logic [7:0]   rx_last_keep;

   task automatic push_be(input logic [47:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) fr_q.push_back(v[8*i +: 8]);
   endtask

   task automatic make_tlp(input int len);
      tlp_q = {};
      for (int i = 0; i < len; i++) tlp_q.push_back(8'($urandom));
   endtask

   // Reference frame: header fields laid out byte by byte, checksum folded until it fits 16 bits.
   task automatic build_expected(input logic [31:0] ts);
      int unsigned s;
      logic [15:0] c;
      logic [63:0] d;
      logic [7:0]  k;
      int nw;
      fr_q = {};
      push_be(dst_mac, 6); push_be(src_mac, 6); push_be(48'h0800, 2);
      push_be(48'h4500, 2); push_be(48'(34 + tlp_q.size()), 2); push_be({32'h0, exp_seq}, 2);
      push_be(48'h4000, 2); push_be({40'h0, TTL}, 1); push_be(48'd17, 1); push_be(48'h0, 2);
      push_be({16'h0, src_ip}, 4); push_be({16'h0, dst_ip}, 4);
      push_be({32'h0, src_port}, 2); push_be({32'h0, dst_port}, 2);
      push_be(48'(14 + tlp_q.size()), 2); push_be(48'h0, 2);
      push_be({32'h0, exp_seq}, 2); push_be({16'h0, ts}, 4);
      s = 0;
      for (int i = 14; i < 34; i += 2) s += {fr_q[i], fr_q[i+1]};
      while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
      c = ~16'(s);
      fr_q[24] = c[15:8];
      fr_q[25] = c[7:0];
      foreach (tlp_q[i]) fr_q.push_back(tlp_q[i]);
      exp_dat = {};
      exp_keep = {};
      nw = (fr_q.size() + 7) / 8;
      if (tlp_q.size() == 0) nw++;
      for (int w = 0; w < nw; w++) begin
         d = '0;
         k = '0;
         for (int j = 0; j < 8; j++)
            if (8*w + j < fr_q.size()) begin
               d[8*j +: 8] = fr_q[8*w + j];
               k[j] = 1'b1;
            end
         exp_dat.push_back(d);
         exp_keep.push_back(k);
      end
   endtask

   task automatic send_tlp(output logic [31:0] ts);
      int nw, len, wait_n;
      logic [63:0] d;
      logic [7:0]  k;
      len = tlp_q.size();
      nw  = (len == 0) ? 1 : (len + 7) / 8;
      ts  = '0;
      for (int w = 0; w < nw; w++) begin
         @(negedge eth_clk);
         d = '0;
         k = '0;
         for (int j = 0; j < 8; j++)
            if (8*w + j < len) begin
               d[8*j +: 8] = tlp_q[8*w + j];
               k[j] = 1'b1;
            end
         tlp_if.tvalid = 1'b1;
         tlp_if.tdata  = d;
         tlp_if.tkeep  = k;
         tlp_if.tlast  = (w == nw - 1);
         wait_n = 0;
         while (tlp_if.tready !== 1'b1 && wait_n < 2000) begin
            @(negedge eth_clk);
            wait_n++;
         end
         if (tlp_if.tready !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_tlp: tlp_tready=%b after %0d cycles, required 1", tlp_if.tready, wait_n);
            tlp_if.tvalid = 1'b0;
            return;
         end
         if (w == nw - 1) ts = tstamp;
      end
      @(negedge eth_clk);
      tlp_if.tvalid = 1'b0;
      tlp_if.tlast  = 1'b0;
   endtask

   // Drains one frame with pct% ready, scoring every accepted word and every stalled cycle.
   task automatic recv_frame(input string name, input int pct, input int stop_after);
      int   idx = 0, cyc = 0;
      bit   done = 0, stall = 0, r;
      logic [63:0] hd = '0;
      logic [7:0]  hk = '0;
      logic        hl = 1'b0;
      rx_q = {};
      while (!done && cyc < 3000) begin
         @(negedge eth_clk);
         cyc++;
         if (stall) begin
            n_chk++;
            if (tx_if.tvalid !== 1'b1 || tx_if.tdata !== hd || tx_if.tkeep !== hk || tx_if.tlast !== hl) begin
               n_fail++;
               $display("FAIL %s stall_hold: vld=%b dat=%h keep=%h last=%b, required vld=1 dat=%h keep=%h last=%b",
                        name, tx_if.tvalid, tx_if.tdata, tx_if.tkeep, tx_if.tlast, hd, hk, hl);
            end
         end
         r = ($urandom_range(99) < pct);
         tx_if.tready = r;
         stall = (tx_if.tvalid === 1'b1) && !r;
         hd = tx_if.tdata;
         hk = tx_if.tkeep;
         hl = tx_if.tlast;
         if (tx_if.tvalid === 1'b1 && r) begin
            n_chk++;
            if (idx >= exp_dat.size()) begin
               n_fail++;
               $display("FAIL %s extra_word %0d: dat=%h keep=%h, required no word", name, idx, tx_if.tdata, tx_if.tkeep);
            end else if (tx_if.tdata !== exp_dat[idx] || tx_if.tkeep !== exp_keep[idx] ||
                         tx_if.tlast !== 1'(idx == exp_dat.size() - 1)) begin
               n_fail++;
               $display("FAIL %s word %0d: dat=%h keep=%h last=%b, required dat=%h keep=%h last=%b", name, idx,
                        tx_if.tdata, tx_if.tkeep, tx_if.tlast, exp_dat[idx], exp_keep[idx], idx == exp_dat.size() - 1);
            end
            for (int j = 0; j < 8; j++) rx_q.push_back(tx_if.tdata[8*j +: 8]);
            rx_last_keep = tx_if.tkeep;
            idx++;
            if (tx_if.tlast === 1'b1 || (stop_after > 0 && idx == stop_after)) done = 1;
         end
      end
      @(negedge eth_clk);
      tx_if.tready = 1'b0;
      rx_words = idx;
      if (stop_after == 0) begin
         n_chk++;
         if (!done || idx != exp_dat.size()) begin
            n_fail++;
            $display("FAIL %s word_count: got %0d (done=%0d), required %0d", name, idx, done, exp_dat.size());
         end
         exp_seq++;
      end
   endtask

   task automatic test_reset;
      eth_rst = 1'b1;
      repeat (3) @(negedge eth_clk);
      n_chk++;
      if ({tx_if.tvalid, tx_if.tdata, tx_if.tkeep, tx_if.tlast, tx_if.tuser} !== 75'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: vld=%b dat=%h keep=%h last=%b user=%b, required all 0",
                  tx_if.tvalid, tx_if.tdata, tx_if.tkeep, tx_if.tlast, tx_if.tuser);
      end
      n_chk++;
      if (tlp_if.tready !== 1'b0 || drop_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_ready_drop: tready=%b drop_cnt=%0d, required 0 and 0", tlp_if.tready, drop_cnt);
      end
      eth_rst = 1'b0;
      #1;
      n_chk++;
      if (tlp_if.tready !== 1'b0) begin
         n_fail++;
         $display("FAIL release_tready: got %b, required 0 before first edge", tlp_if.tready);
      end
      @(negedge eth_clk);
      n_chk++;
      if (tlp_if.tready !== 1'b1) begin
         n_fail++;
         $display("FAIL first_cycle_tready: got %b, required 1", tlp_if.tready);
      end
   endtask

   task automatic test_mrd;
      logic [31:0] ts;
      int unsigned s;
      make_tlp(12);
      send_tlp(ts);
      n_chk++;
      if (tlp_if.tready !== 1'b0 || tx_if.tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL mrd_csum_cycle: tready=%b tvalid=%b, required 0 and 0", tlp_if.tready, tx_if.tvalid);
      end
      @(negedge eth_clk);
      n_chk++;
      if (tx_if.tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL mrd_latency_early: tvalid=%b one cycle after tlast, required 0", tx_if.tvalid);
      end
      @(negedge eth_clk);
      n_chk++;
      if (tx_if.tvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL mrd_latency: tvalid=%b two cycles after tlast, required 1", tx_if.tvalid);
      end
      build_expected(ts);
      recv_frame("mrd", 100, 0);
      n_chk++;
      if (rx_words != 8 || rx_last_keep !== 8'h0F) begin
         n_fail++;
         $display("FAIL mrd_shape: words=%0d last_keep=%h, required 8 and 0f", rx_words, rx_last_keep);
      end
      n_chk++;
      if ({rx_q[16], rx_q[17]} !== 16'd46 || {rx_q[38], rx_q[39]} !== 16'd26 || {rx_q[18], rx_q[19]} !== 16'd0) begin
         n_fail++;
         $display("FAIL mrd_fields: ip_len=%0d udp_len=%0d id=%0d, required 46 26 0",
                  {rx_q[16], rx_q[17]}, {rx_q[38], rx_q[39]}, {rx_q[18], rx_q[19]});
      end
      s = 0;
      for (int i = 14; i < 34; i += 2) s += {rx_q[i], rx_q[i+1]};
      while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
      n_chk++;
      if (s != 32'hffff) begin
         n_fail++;
         $display("FAIL mrd_ip_checksum: header sum %h, required ffff", s);
      end
   endtask

   task automatic test_mwr;
      logic [31:0] ts;
      make_tlp(272);
      send_tlp(ts);
      build_expected(ts);
      recv_frame("mwr", 100, 0);
      n_chk++;
      if (rx_words != 40 || {rx_q[16], rx_q[17]} !== 16'd306 || {rx_q[38], rx_q[39]} !== 16'd286) begin
         n_fail++;
         $display("FAIL mwr_fields: words=%0d ip_len=%0d udp_len=%0d, required 40 306 286",
                  rx_words, {rx_q[16], rx_q[17]}, {rx_q[38], rx_q[39]});
      end
      n_chk++;
      if ({rx_q[24], rx_q[25]} !== {fr_q[24], fr_q[25]}) begin
         n_fail++;
         $display("FAIL mwr_checksum: got %h, required %h", {rx_q[24], rx_q[25]}, {fr_q[24], fr_q[25]});
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] ts;
      logic [15:0] id0, id1, want;
      want = exp_seq;
      make_tlp(12);
      send_tlp(ts);
      build_expected(ts);
      recv_frame("b2b_0", 100, 0);
      id0 = {rx_q[18], rx_q[19]};
      make_tlp(24);
      send_tlp(ts);
      build_expected(ts);
      recv_frame("b2b_1", 100, 0);
      id1 = {rx_q[18], rx_q[19]};
      n_chk++;
      if (id0 !== want || id1 !== want + 16'd1) begin
         n_fail++;
         $display("FAIL b2b_seq: ids %0d,%0d, required %0d,%0d", id0, id1, want, want + 16'd1);
      end
   endtask

   task automatic test_oversize;
      logic [31:0] ts;
      logic [15:0] seq_before;
      bit          saw_vld;
      seq_before = exp_seq;
      make_tlp(520);
      send_tlp(ts);
      saw_vld = 0;
      tx_if.tready = 1'b1;
      repeat (20) begin
         @(negedge eth_clk);
         if (tx_if.tvalid === 1'b1) saw_vld = 1;
      end
      tx_if.tready = 1'b0;
      n_chk++;
      if (saw_vld || drop_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL oversize_65: frame_seen=%0d drop_cnt=%0d, required 0 and 1", saw_vld, drop_cnt);
      end
      make_tlp(560);
      send_tlp(ts);
      repeat (4) @(negedge eth_clk);
      n_chk++;
      if (drop_cnt !== 16'd2 || tx_if.tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL oversize_70: drop_cnt=%0d tvalid=%b, required 2 and 0", drop_cnt, tx_if.tvalid);
      end
      make_tlp(16);
      send_tlp(ts);
      build_expected(ts);
      recv_frame("after_drop", 100, 0);
      n_chk++;
      if ({rx_q[18], rx_q[19]} !== seq_before) begin
         n_fail++;
         $display("FAIL after_drop_seq: id=%0d, required %0d", {rx_q[18], rx_q[19]}, seq_before);
      end
   endtask

   task automatic test_random;
      logic [31:0] ts;
      int len;
      for (int i = 0; i < 100; i++) begin
         len = (i == 0) ? 512 : (i == 1) ? 0 : int'($urandom_range(512, 0));
         make_tlp(len);
         send_tlp(ts);
         build_expected(ts);
         recv_frame($sformatf("rand%0d_len%0d", i, len), 50, 0);
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [31:0] ts;
      make_tlp(128);
      send_tlp(ts);
      build_expected(ts);
      recv_frame("rst_pre", 100, 16);
      n_chk++;
      if (tx_if.tvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_active: tvalid=%b at data word 10, required 1", tx_if.tvalid);
      end
      eth_rst = 1'b1;
      #1;
      n_chk++;
      if (tx_if.tvalid !== 1'b0 || tlp_if.tready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_drop: tvalid=%b tready=%b, required 0 and 0", tx_if.tvalid, tlp_if.tready);
      end
      @(negedge eth_clk);
      eth_rst = 1'b0;
      exp_seq = 16'd0;
      @(negedge eth_clk);
      n_chk++;
      if (drop_cnt !== 16'd0 || tlp_if.tready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_release: drop_cnt=%0d tready=%b, required 0 and 1", drop_cnt, tlp_if.tready);
      end
      make_tlp(40);
      send_tlp(ts);
      build_expected(ts);
      recv_frame("rst_post", 50, 0);
      n_chk++;
      if ({rx_q[18], rx_q[19]} !== 16'd0) begin
         n_fail++;
         $display("FAIL rst_post_seq: id=%0d, required 0", {rx_q[18], rx_q[19]});
      end
   endtask

   initial begin
      tlp_if.tvalid = 1'b0;
      tlp_if.tdata  = '0;
      tlp_if.tkeep  = '0;
      tlp_if.tlast  = 1'b0;
      tlp_if.tuser  = 1'b0;
      tx_if.tready  = 1'b0;
      test_reset();
      test_mrd();
      test_mwr();
      test_back_to_back();
      test_oversize();
      test_random();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
